// File: rtl/rob_multi_commit_pkg.sv
// rtl/rob_multi_commit_pkg.sv - shared ROB types, default sizes and helpers
package rob_multi_commit_pkg;

  localparam int ROB_DEPTH    = 8;
  localparam int ROB_COMMIT_W = 2;
  localparam int ROB_DATA_W   = 32;
  localparam int ROB_ARCH_W   = 5;
  localparam int ROB_PHY_W    = 6;
  localparam int ROB_PC_W     = 32;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_addr_t;

  // One ROB slot at the default back-end widths
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  mispredict;
    logic                  is_branch;
    logic [ROB_ARCH_W-1:0] dest_arch;
    logic [ROB_PHY_W-1:0]  dest_phy;
    logic [ROB_PHY_W-1:0]  old_phy;
    logic [ROB_DATA_W-1:0] value;
    logic [ROB_PC_W-1:0]   target_pc;
  } rob_entry_t;

  // Width needed to hold a retire count of 0..commit_w
  function automatic int rob_cnt_w(input int commit_w);
    return $clog2(commit_w + 1);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// rtl/rob_commit_select.sv - picks the in-order run of retirable entries at head
module rob_commit_select
  import rob_multi_commit_pkg::*;
#(
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int CNT_W    = rob_cnt_w(COMMIT_W),
  parameter int SLOT_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  logic [COMMIT_W-1:0] win_valid_i,
  input  logic [COMMIT_W-1:0] win_done_i,
  input  logic [COMMIT_W-1:0] win_mispredict_i,
  output logic [COMMIT_W-1:0] elig_mask_o,
  output logic [CNT_W-1:0]    commit_cnt_o,
  output logic                flush_req_o,
  output logic [SLOT_W-1:0]   flush_slot_o
);

  // Walk from the oldest slot; stop at the first unfinished entry or just after a mispredict
  always_comb begin
    logic run;
    run          = 1'b1;
    elig_mask_o  = '0;
    commit_cnt_o = '0;
    flush_req_o  = 1'b0;
    flush_slot_o = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (run && win_valid_i[k] && win_done_i[k]) begin
        elig_mask_o[k] = 1'b1;
        commit_cnt_o   = commit_cnt_o + CNT_W'(1);
        if (win_mispredict_i[k]) begin
          flush_req_o  = 1'b1;
          flush_slot_o = SLOT_W'(k);
          run          = 1'b0;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// rtl/rob_multi_commit.sv - reorder buffer with multi-entry commit and precise flush
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int ARCH_W   = ROB_ARCH_W,
  parameter int PHY_W    = ROB_PHY_W,
  parameter int PC_W     = ROB_PC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic [ARCH_W-1:0]            alloc_dest_arch,
  input  logic [PHY_W-1:0]             alloc_dest_phy,
  input  logic [PHY_W-1:0]             alloc_old_phy,
  input  logic                         alloc_is_branch,
  output logic                         alloc_ready,
  output logic [$clog2(DEPTH)-1:0]     alloc_rob_addr,
  input  logic                         wb_en,
  input  logic [$clog2(DEPTH)-1:0]     wb_rob_addr,
  input  logic [DATA_W-1:0]            wb_value,
  input  logic                         wb_mispredict,
  input  logic [PC_W-1:0]              wb_target_pc,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*ARCH_W-1:0]   commit_dest_arch,
  output logic [COMMIT_W*PHY_W-1:0]    commit_dest_phy,
  output logic [COMMIT_W*DATA_W-1:0]   commit_value,
  output logic [COMMIT_W*PHY_W-1:0]    commit_free_phy,
  output logic                         flush,
  output logic [PC_W-1:0]              flush_pc,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int CNT_W  = rob_cnt_w(COMMIT_W);
  localparam int SLOT_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispredict;
    logic              is_branch;
    logic [ARCH_W-1:0] dest_arch;
    logic [PHY_W-1:0]  dest_phy;
    logic [PHY_W-1:0]  old_phy;
    logic [DATA_W-1:0] value;
    logic [PC_W-1:0]   target_pc;
  } entry_t;

  entry_t                rob_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [PTR_W-1:0]      head_d;

  logic [COMMIT_W-1:0]        commit_valid_q;
  logic [COMMIT_W*ARCH_W-1:0] commit_dest_arch_q;
  logic [COMMIT_W*PHY_W-1:0]  commit_dest_phy_q;
  logic [COMMIT_W*DATA_W-1:0] commit_value_q;
  logic [COMMIT_W*PHY_W-1:0]  commit_free_phy_q;
  logic                       flush_q;
  logic [PC_W-1:0]            flush_pc_q;

  entry_t              win_e [COMMIT_W];
  logic [IDX_W-1:0]    win_idx [COMMIT_W];
  logic [COMMIT_W-1:0] win_valid, win_done, win_mis;
  logic [COMMIT_W-1:0] sel_mask;
  logic [CNT_W-1:0]    sel_cnt;
  logic                sel_flush;
  logic [SLOT_W-1:0]   sel_slot;
  logic [PC_W-1:0]     flush_target;
  logic                alloc_take;
  entry_t              alloc_entry;

  // Occupancy comes straight from the wrap-bit pointers
  always_comb begin
    full           = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
    empty          = (head_q == tail_q);
    count          = tail_q - head_q;
    alloc_ready    = !full;
    alloc_rob_addr = tail_q[IDX_W-1:0];
  end

  // Gather the COMMIT_W oldest entries; only branches can request a redirect
  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) begin
      win_idx[k]   = head_q[IDX_W-1:0] + IDX_W'(k);
      win_e[k]     = rob_q[win_idx[k]];
      win_valid[k] = win_e[k].valid;
      win_done[k]  = win_e[k].done;
      win_mis[k]   = win_e[k].mispredict & win_e[k].is_branch;
    end
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CNT_W),
    .SLOT_W   (SLOT_W)
  ) u_select (
    .win_valid_i      (win_valid),
    .win_done_i       (win_done),
    .win_mispredict_i (win_mis),
    .elig_mask_o      (sel_mask),
    .commit_cnt_o     (sel_cnt),
    .flush_req_o      (sel_flush),
    .flush_slot_o     (sel_slot)
  );

  // Next head, redirect target and the entry image written on allocation
  always_comb begin
    head_d       = head_q + PTR_W'(sel_cnt);
    alloc_take   = alloc_en && !full && !sel_flush;
    flush_target = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (SLOT_W'(k) == sel_slot) flush_target = win_e[k].target_pc;
    end
    alloc_entry           = '0;
    alloc_entry.valid     = 1'b1;
    alloc_entry.is_branch = alloc_is_branch;
    alloc_entry.dest_arch = alloc_dest_arch;
    alloc_entry.dest_phy  = alloc_dest_phy;
    alloc_entry.old_phy   = alloc_old_phy;
  end

  // Entry array and pointers: writeback, allocate, retire, then flush wipes everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
    end else begin
      if (wb_en && rob_q[wb_rob_addr].valid) begin
        rob_q[wb_rob_addr].done       <= 1'b1;
        rob_q[wb_rob_addr].value      <= wb_value;
        rob_q[wb_rob_addr].mispredict <= wb_mispredict;
        rob_q[wb_rob_addr].target_pc  <= wb_target_pc;
      end
      if (alloc_take) rob_q[tail_q[IDX_W-1:0]] <= alloc_entry;
      for (int k = 0; k < COMMIT_W; k++) begin
        if (sel_mask[k]) begin
          rob_q[win_idx[k]].valid <= 1'b0;
          rob_q[win_idx[k]].done  <= 1'b0;
        end
      end
      head_q <= head_d;
      if (sel_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          rob_q[i].valid <= 1'b0;
          rob_q[i].done  <= 1'b0;
        end
        tail_q <= head_d;
      end else if (alloc_take) begin
        tail_q <= tail_q + PTR_W'(1);
      end
    end
  end

  // Registered retire and flush strobes, visible for the cycle after the commit edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_valid_q     <= '0;
      commit_dest_arch_q <= '0;
      commit_dest_phy_q  <= '0;
      commit_value_q     <= '0;
      commit_free_phy_q  <= '0;
      flush_q            <= 1'b0;
      flush_pc_q         <= '0;
    end else begin
      commit_valid_q <= sel_mask;
      for (int k = 0; k < COMMIT_W; k++) begin
        commit_dest_arch_q[k*ARCH_W +: ARCH_W] <= win_e[k].dest_arch;
        commit_dest_phy_q[k*PHY_W +: PHY_W]    <= win_e[k].dest_phy;
        commit_value_q[k*DATA_W +: DATA_W]     <= win_e[k].value;
        commit_free_phy_q[k*PHY_W +: PHY_W]    <= win_e[k].old_phy;
      end
      flush_q <= sel_flush;
      if (sel_flush) flush_pc_q <= flush_target;
    end
  end

  assign commit_valid     = commit_valid_q;
  assign commit_dest_arch = commit_dest_arch_q;
  assign commit_dest_phy  = commit_dest_phy_q;
  assign commit_value     = commit_value_q;
  assign commit_free_phy  = commit_free_phy_q;
  assign flush            = flush_q;
  assign flush_pc         = flush_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb/tb_rob_multi_commit.sv - directed self-checking bench for rob_multi_commit
module tb_rob_multi_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_en;
  logic [4:0]  alloc_dest_arch;
  logic [5:0]  alloc_dest_phy;
  logic [5:0]  alloc_old_phy;
  logic        alloc_is_branch;
  logic        alloc_ready;
  logic [2:0]  alloc_rob_addr;
  logic        wb_en;
  logic [2:0]  wb_rob_addr;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic [31:0] wb_target_pc;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_dest_arch;
  logic [11:0] commit_dest_phy;
  logic [63:0] commit_value;
  logic [11:0] commit_free_phy;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  rob_multi_commit #(
    .DEPTH(8), .COMMIT_W(2), .DATA_W(32), .ARCH_W(5), .PHY_W(6), .PC_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_dest_arch(alloc_dest_arch), .alloc_dest_phy(alloc_dest_phy),
    .alloc_old_phy(alloc_old_phy), .alloc_is_branch(alloc_is_branch),
    .alloc_ready(alloc_ready), .alloc_rob_addr(alloc_rob_addr),
    .wb_en(wb_en), .wb_rob_addr(wb_rob_addr), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
    .commit_valid(commit_valid), .commit_dest_arch(commit_dest_arch),
    .commit_dest_phy(commit_dest_phy), .commit_value(commit_value),
    .commit_free_phy(commit_free_phy), .flush(flush), .flush_pc(flush_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        al;
    logic        wb;
    logic [2:0]  wa;
    logic [31:0] wv;
    logic        rdy;
    logic [2:0]  addr;
    logic [3:0]  cnt;
    logic        full;
    logic [1:0]  cv;
    logic [31:0] v0;
    logic [31:0] v1;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic al, logic wb, logic [2:0] wa, logic [31:0] wv, logic rdy,
                              logic [2:0] addr, logic [3:0] cnt, logic fl, logic [1:0] cv,
                              logic [31:0] v0, logic [31:0] v1);
    vec_t v;
    v.al = al; v.wb = wb; v.wa = wa; v.wv = wv; v.rdy = rdy; v.addr = addr;
    v.cnt = cnt; v.full = fl; v.cv = cv; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; alloc_en = 1'b0; alloc_dest_arch = '0; alloc_dest_phy = '0;
    alloc_old_phy = '0; alloc_is_branch = 1'b0; wb_en = 1'b0; wb_rob_addr = '0;
    wb_value = '0; wb_mispredict = 1'b0; wb_target_pc = '0;
    do_reset();

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_cv", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_ready", alloc_ready, 1);

    // Fill to full, refused 9th alloc, commit vs refused alloc on a full ROB, out-of-order completion
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, 0, 0, 0, 1, 3'(i), 4'(i + 1), (i == 7), 2'b00, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0,          0, 0, 8, 1, 2'b00, 0, 0);
    vecs[9]  = mk(0, 1, 0, 32'hA0,     0, 0, 8, 1, 2'b00, 0, 0);
    vecs[10] = mk(1, 0, 0, 0,          0, 0, 7, 0, 2'b01, 32'hA0, 0);
    vecs[11] = mk(1, 0, 0, 0,          1, 0, 8, 1, 2'b00, 0, 0);
    vecs[12] = mk(0, 1, 2, 32'hB2,     0, 0, 8, 1, 2'b00, 0, 0);
    vecs[13] = mk(0, 1, 1, 32'hB1,     0, 0, 8, 1, 2'b00, 0, 0);
    vecs[14] = mk(0, 0, 0, 0,          0, 0, 6, 0, 2'b11, 32'hB1, 32'hB2);
    vecs[15] = mk(0, 1, 3, 32'hB3,     1, 0, 6, 0, 2'b00, 0, 0);
    vecs[16] = mk(0, 0, 0, 0,          1, 0, 5, 0, 2'b01, 32'hB3, 0);

    for (int i = 0; i < 17; i++) begin
      alloc_en = vecs[i].al; wb_en = vecs[i].wb;
      wb_rob_addr = vecs[i].wa; wb_value = vecs[i].wv;
      chk($sformatf("v%0d_ready", i), alloc_ready, vecs[i].rdy);
      if (vecs[i].al && vecs[i].rdy) chk($sformatf("v%0d_addr", i), alloc_rob_addr, vecs[i].addr);
      tick();
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_full", i), full, vecs[i].full);
      chk($sformatf("v%0d_cv", i), commit_valid, vecs[i].cv);
      if (vecs[i].cv[0]) chk($sformatf("v%0d_val0", i), commit_value[31:0], vecs[i].v0);
      if (vecs[i].cv[1]) chk($sformatf("v%0d_val1", i), commit_value[63:32], vecs[i].v1);
    end
    alloc_en = 1'b0; wb_en = 1'b0;

    // Mispredicted branch in slot 1: both retire, flush, younger entries dropped
    do_reset();
    alloc_is_branch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc_en = 1'b1;
      alloc_dest_arch = 5'(i + 1);
      alloc_old_phy = 6'(i + 20);
      tick();
    end
    alloc_en = 1'b0; alloc_is_branch = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      wb_en = 1'b1; wb_rob_addr = 3'(i); wb_value = 32'(i + 10);
      wb_mispredict = (i == 1); wb_target_pc = (i == 1) ? 32'h100 : 32'h0;
      tick();
    end
    wb_en = 1'b0; wb_mispredict = 1'b0;
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    chk("mp_cv", commit_valid, 2'b11);
    chk("mp_val0", commit_value[31:0], 10);
    chk("mp_val1", commit_value[63:32], 11);
    chk("mp_arch1", commit_dest_arch[9:5], 2);
    chk("mp_free0", commit_free_phy[5:0], 20);
    chk("mp_flush", flush, 1);
    chk("mp_flush_pc", flush_pc, 32'h100);
    chk("mp_count", count, 0);
    chk("mp_empty", empty, 1);
    chk("mp_tail", alloc_rob_addr, 2);
    tick();
    chk("mp_flush_drop", flush, 0);
    chk("mp_cv_after", commit_valid, 0);
    tick();
    chk("mp_no_young", commit_valid, 0);
    chk("mp_count_after", count, 0);

    // Twenty single-entry rounds to exercise pointer wrap
    do_reset();
    for (int r = 0; r < 20; r++) begin
      alloc_en = 1'b1;
      chk($sformatf("wrap%0d_addr", r), alloc_rob_addr, 64'(r % 8));
      tick();
      alloc_en = 1'b0;
      chk($sformatf("wrap%0d_cnt", r), count, 1);
      wb_en = 1'b1; wb_rob_addr = 3'(r % 8); wb_value = 32'h1000 + 32'(r);
      tick();
      wb_en = 1'b0;
      tick();
      chk($sformatf("wrap%0d_cv", r), commit_valid, 2'b01);
      chk($sformatf("wrap%0d_val", r), commit_value[31:0], 64'(32'h1000 + 32'(r)));
      chk($sformatf("wrap%0d_cnt0", r), count, 0);
    end

    // Reset with five entries in flight, one of them about to retire
    for (int i = 0; i < 5; i++) begin
      alloc_en = 1'b1;
      if (i == 0) chk("mid_first_addr", alloc_rob_addr, 4);
      tick();
    end
    alloc_en = 1'b0;
    chk("mid_count5", count, 5);
    wb_en = 1'b1; wb_rob_addr = 3'd4; wb_value = 32'hDEAD;
    tick();
    wb_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_cv", commit_valid, 0);
    chk("mid_flush", flush, 0);
    rst = 1'b1;
    wb_en = 1'b1; wb_rob_addr = 3'd0; wb_value = 32'hBEEF;
    tick();
    wb_en = 1'b0;
    chk("mid_wb_ign_cnt", count, 0);
    chk("mid_wb_ign_cv", commit_valid, 0);
    alloc_en = 1'b1;
    chk("mid_realloc_addr", alloc_rob_addr, 0);
    tick();
    alloc_en = 1'b0;
    tick();
    tick();
    chk("mid_realloc_cv", commit_valid, 0);
    chk("mid_realloc_cnt", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
